// File: rtl/hemaia_clk_pkg.sv
// Shared types and constants for the HeMAiA clock divider.
// Divider channels and the multi-channel top import this package.
package hemaia_clk_pkg;

    localparam int unsigned DefaultDivWidth = 8;

    typedef logic [DefaultDivWidth-1:0] div_t;

    localparam int unsigned DivGate = 0;

    localparam logic DivRstLevel = 1'b1;

endpackage

// File: rtl/hemaia_clock_divider_channel.sv
// One divided-clock channel: counter, reconfiguration handshake,
// 50%-duty output shaping, bypass mux for divide-by-1 and final gate.
module hemaia_clock_divider_channel
    import hemaia_clk_pkg::*;
#(
    parameter int unsigned MaxDivisionWidth = 8,
    parameter int unsigned DefaultDivision  = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        test_mode_i,
    input  logic                        sync_i,
    input  logic [MaxDivisionWidth-1:0] divisor_i,
    input  logic                        divisor_valid_i,
    output logic                        divisor_ready_o,
    output logic [MaxDivisionWidth-1:0] divisor_q_o,
    output logic                        gated_o,
    output logic                        clk_o
);

    localparam int unsigned W = MaxDivisionWidth;
    localparam logic [W-1:0] DefDiv  = W'(DefaultDivision);
    localparam logic [W-1:0] GateDiv = W'(DivGate);
    localparam logic         DefSel  = (DefaultDivision == 1);

    logic [W-1:0] cnt;
    logic [W-1:0] div_q;
    logic [W-1:0] pending_div;
    logic         gated;
    logic         pending;

    logic at_wrap;
    logic boundary;
    logic accept;
    logic apply;
    logic raw;

    (* keep = "true", dont_touch = "true" *) logic d1;
    (* keep = "true", dont_touch = "true" *) logic d2;
    (* keep = "true", dont_touch = "true" *) logic sel_bypass;
    (* keep = "true", dont_touch = "true" *) logic div_clk;
    (* keep = "true", dont_touch = "true" *) logic mux_clk;

    assign at_wrap  = (cnt == div_q - 1'b1);
    assign boundary = gated | at_wrap | sync_i;
    assign accept   = divisor_valid_i & ~pending;
    assign apply    = pending & boundary;
    assign raw      = (cnt >= (div_q >> 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt         <= '0;
            div_q       <= DefDiv;
            gated       <= 1'b0;
            pending     <= 1'b0;
            pending_div <= GateDiv;
        end else begin
            if (accept) begin
                pending     <= 1'b1;
                pending_div <= divisor_i;
            end
            if (apply) begin
                pending <= 1'b0;
                if (pending_div != GateDiv) begin
                    div_q <= pending_div;
                    gated <= 1'b0;
                    cnt   <= '0;
                end else begin
                    gated <= 1'b1;
                end
            end else if (!gated) begin
                cnt <= (sync_i || at_wrap) ? '0 : cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) d1 <= DivRstLevel;
        else         d1 <= raw;
    end

    // Falling-edge stages give the extra half cycle needed by odd divisors
    // and keep the bypass select change inside the low phase of clk_i.
    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            d2         <= DivRstLevel;
            sel_bypass <= DefSel;
        end else begin
            d2         <= d1;
            sel_bypass <= (div_q == W'(1));
        end
    end

    assign div_clk = div_q[0] ? ~(d1 & d2) : ~d1;

    (* keep = "true", dont_touch = "true" *)
    tc_clk_mux2 u_clk_mux (
        .clk0_i    (div_clk),
        .clk1_i    (clk_i),
        .clk_sel_i (sel_bypass),
        .clk_o     (mux_clk)
    );

    (* keep = "true", dont_touch = "true" *)
    tc_clk_gating u_clk_gate (
        .clk_i     (mux_clk),
        .en_i      (~gated & rst_ni),
        .test_en_i (test_mode_i),
        .clk_o     (clk_o)
    );

    assign divisor_ready_o = ~pending;
    assign divisor_q_o     = div_q;
    assign gated_o         = gated;

    a_div_nonzero : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (DefaultDivision != 0) && (div_q != '0)
    );

endmodule

// File: rtl/tc_clk_gating.sv
// Generic latch-based clock gate cell.
// Technology libraries replace this with an integrated clock gate.
module tc_clk_gating (
    input  logic clk_i,
    input  logic en_i,
    input  logic test_en_i,
    output logic clk_o
);

    logic clk_en;

    always_latch begin
        if (!clk_i) clk_en = en_i | test_en_i;
    end

    assign clk_o = clk_i & clk_en;

endmodule

// File: rtl/tc_clk_mux2.sv
// Generic clock mux cell.
// Technology libraries replace this with a hardened glitch-safe mux.
module tc_clk_mux2 (
    input  logic clk0_i,
    input  logic clk1_i,
    input  logic clk_sel_i,
    output logic clk_o
);

    assign clk_o = clk_sel_i ? clk1_i : clk0_i;

endmodule

// File: rtl/hemaia_multi_clock_divider.sv
// N-channel programmable clock divider fed from one root clock.
// Each channel is fully independent apart from the shared sync pulse.
module hemaia_multi_clock_divider
    import hemaia_clk_pkg::*;
#(
    parameter int unsigned NumChannels      = 4,
    parameter int unsigned MaxDivisionWidth = 8,
    parameter int unsigned DefaultDivision  = 1
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic                                    test_mode_i,
    input  logic                                    sync_i,
    input  logic [NumChannels*MaxDivisionWidth-1:0] divisor_i,
    input  logic [NumChannels-1:0]                  divisor_valid_i,
    output logic [NumChannels-1:0]                  divisor_ready_o,
    output logic [NumChannels*MaxDivisionWidth-1:0] divisor_q_o,
    output logic [NumChannels-1:0]                  gated_o,
    output logic [NumChannels-1:0]                  clk_o
);

    localparam int unsigned W = MaxDivisionWidth;

    for (genvar i = 0; i < NumChannels; i++) begin : gen_ch
        hemaia_clock_divider_channel #(
            .MaxDivisionWidth (MaxDivisionWidth),
            .DefaultDivision  (DefaultDivision)
        ) u_channel (
            .clk_i           (clk_i),
            .rst_ni          (rst_ni),
            .test_mode_i     (test_mode_i),
            .sync_i          (sync_i),
            .divisor_i       (divisor_i[i*W +: W]),
            .divisor_valid_i (divisor_valid_i[i]),
            .divisor_ready_o (divisor_ready_o[i]),
            .divisor_q_o     (divisor_q_o[i*W +: W]),
            .gated_o         (gated_o[i]),
            .clk_o           (clk_o[i])
        );
    end

endmodule
